// File: rtl/button_conditioner.sv
// Per-channel polarity fix, 2-FF sync, debounce and press/release pulses; define BTN_AUTOREPEAT_EN for held-key repeats.
// Latency 2+DEBOUNCE_CYCLES edges from a steady pin change; no backpressure, all outputs registered.
module button_conditioner #(
   parameter int NUM_BTN         = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic [NUM_BTN-1:0] btn_level_o,
   output logic [NUM_BTN-1:0] btn_press_o,
   output logic [NUM_BTN-1:0] btn_release_o,
   output logic               any_press_o
);

   localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_ALL = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] pin_pressed;
   logic [NUM_BTN-1:0] sync_q;
   logic [NUM_BTN-1:0] samp_q;
   logic [NUM_BTN-1:0] level_q;
   logic [NUM_BTN-1:0] level_d;
   logic [NUM_BTN-1:0] press_d;
   logic [NUM_BTN-1:0] release_d;
   logic [NUM_BTN-1:0] accept;
   logic [NUM_BTN-1:0] press_all;
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];

   // Work internally in "1 = pressed" so reset value 0 always means released.
   assign pin_pressed = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         samp_q <= '0;
      end else begin
         sync_q <= pin_pressed;
         samp_q <= sync_q;
      end
   end

   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      accept    = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (samp_q[i] != level_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               accept[i]    = 1'b1;
               level_d[i]   = samp_q[i];
               press_d[i]   = samp_q[i];
               release_d[i] = ~samp_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_RATE - 1);

   logic [CNT_W-1:0]   rcnt_q [NUM_BTN];
   logic [CNT_W-1:0]   rcnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] rep_q;
   logic [NUM_BTN-1:0] rep_d;
   logic [NUM_BTN-1:0] rpt_pulse;

   // rep_q selects the shorter inter-repeat period once the first repeat has fired.
   always_comb begin
      rep_d     = rep_q;
      rpt_pulse = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         rcnt_d[i] = '0;
         if (accept[i] || !level_q[i]) begin
            rep_d[i] = 1'b0;
         end else if (rcnt_q[i] == (rep_q[i] ? RPT_NEXT : RPT_FIRST)) begin
            rpt_pulse[i] = 1'b1;
            rep_d[i]     = 1'b1;
         end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_q <= '0;
         for (int i = 0; i < NUM_BTN; i++) rcnt_q[i] <= '0;
      end else begin
         rep_q <= rep_d;
         for (int i = 0; i < NUM_BTN; i++) rcnt_q[i] <= rcnt_d[i];
      end
   end

   assign press_all = press_d | rpt_pulse;
`else
   assign press_all = press_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q       <= '0;
         btn_press_o   <= '0;
         btn_release_o <= '0;
         any_press_o   <= 1'b0;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      end else begin
         level_q       <= level_d;
         btn_press_o   <= press_all;
         btn_release_o <= release_d;
         any_press_o   <= |press_all;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign btn_level_o = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed table, corner sequences and random stimulus vs. a window-based model.
module tb_button_conditioner;

   localparam int N  = 2;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 3;
   localparam int MASK = (1 << D) - 1;

   logic         clk;
   logic         rst;
   logic [N-1:0] btn;
   logic [N-1:0] btn_level, btn_press, btn_release;
   logic         any_press;

   int vectors;
   int miscompares;

   button_conditioner #(
      .NUM_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst(rst), .btn_i(btn),
      .btn_level_o(btn_level), .btn_press_o(btn_press),
      .btn_release_o(btn_release), .any_press_o(any_press)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a change is accepted once the last D synchronised samples all disagree with the level.
   logic [N-1:0] m_ps1, m_ps2, m_lvl, m_prs, m_rel;
   int           m_hist [N];
   int           m_held [N];

   function automatic void model_edge(input logic r, input logic [N-1:0] b);
      logic s;
      m_prs = '0;
      m_rel = '0;
      if (r) begin
         m_ps1 = '0; m_ps2 = '0; m_lvl = '0;
         for (int i = 0; i < N; i++) begin m_hist[i] = 0; m_held[i] = 0; end
         return;
      end
      for (int i = 0; i < N; i++) begin
         s = m_ps2[i];
         m_hist[i] = ((m_hist[i] << 1) | int'(s)) & 'hff;
         if ((m_hist[i] & MASK) == (m_lvl[i] ? 0 : MASK)) begin
            m_lvl[i] = s;
            m_prs[i] = s;
            m_rel[i] = ~s;
            m_held[i] = 0;
         end else if (m_lvl[i]) begin
            m_held[i]++;
`ifdef BTN_AUTOREPEAT_EN
            if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0))
               m_prs[i] = 1'b1;
`endif
         end
      end
      m_ps2 = m_ps1;
      m_ps1 = ~b;
   endfunction

   task automatic step(input logic r, input logic [N-1:0] b);
      @(negedge clk);
      rst = r;
      btn = b;
      @(posedge clk);
      model_edge(r, b);
      #1;
      vectors++;
      if ({btn_level, btn_press, btn_release, any_press} !== {m_lvl, m_prs, m_rel, |m_prs}) begin
         miscompares++;
         $display("FAIL model @%0t: got lvl/prs/rel/any=%b/%b/%b/%b expected %b/%b/%b/%b",
                  $time, btn_level, btn_press, btn_release, any_press, m_lvl, m_prs, m_rel, |m_prs);
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] btn;
      int           n;
      logic [N-1:0] lvl;
      logic [N-1:0] prs;
      logic [N-1:0] rel;
      logic         any;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int first, cnt;
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      btn = 2'b11;
      m_ps1 = '0; m_ps2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin m_hist[i] = 0; m_held[i] = 0; end

      // Outputs checked after the last cycle of each hold (the model checks every cycle).
      tbl[0]  = '{1'b1, 2'b11,  3, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[1]  = '{1'b0, 2'b11, 20, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[2]  = '{1'b0, 2'b10,  5, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[3]  = '{1'b0, 2'b10,  1, 2'b01, 2'b01, 2'b00, 1'b1};
      tbl[4]  = '{1'b0, 2'b10,  4, 2'b01, 2'b00, 2'b00, 1'b0};
      tbl[5]  = '{1'b0, 2'b11,  5, 2'b01, 2'b00, 2'b00, 1'b0};
      tbl[6]  = '{1'b0, 2'b11,  1, 2'b00, 2'b00, 2'b01, 1'b0};
      tbl[7]  = '{1'b0, 2'b11,  4, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[8]  = '{1'b0, 2'b10,  3, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[9]  = '{1'b0, 2'b11,  8, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[10] = '{1'b0, 2'b00,  5, 2'b00, 2'b00, 2'b00, 1'b0};
      tbl[11] = '{1'b0, 2'b00,  1, 2'b11, 2'b11, 2'b00, 1'b1};
      tbl[12] = '{1'b0, 2'b10,  5, 2'b11, 2'b00, 2'b00, 1'b0};
      tbl[13] = '{1'b0, 2'b10,  1, 2'b01, 2'b00, 2'b10, 1'b0};
      tbl[14] = '{1'b0, 2'b11,  5, 2'b01, 2'b00, 2'b00, 1'b0};
      tbl[15] = '{1'b0, 2'b11,  1, 2'b00, 2'b00, 2'b01, 1'b0};
      tbl[16] = '{1'b0, 2'b11,  4, 2'b00, 2'b00, 2'b00, 1'b0};

      for (int k = 0; k < 17; k++) begin
         for (int c = 0; c < tbl[k].n; c++) step(tbl[k].rst, tbl[k].btn);
         vectors++;
         if ({btn_level, btn_press, btn_release, any_press} !==
             {tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].any}) begin
            miscompares++;
            $display("FAIL table[%0d]: got lvl/prs/rel/any=%b/%b/%b/%b expected %b/%b/%b/%b", k,
                     btn_level, btn_press, btn_release, any_press,
                     tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].any);
         end
      end

      // Bounce on pin 0 for 10 cycles, then steady low: one press, 6 edges after bounce ends.
      first = -1;
      cnt = 0;
      for (int k = 0; k < 19; k++) begin
         step(1'b0, (k < 10 && (k % 2 == 1)) ? 2'b11 : 2'b10);
         if (btn_press[0]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      check("bounce_press_count", cnt, 1);
      check("bounce_press_step", first, 15);
      for (int k = 0; k < 8; k++) step(1'b0, 2'b11);
      check("bounce_released", int'(btn_level), 0);

      // Reset in the middle of a hold: outputs clear, press re-accepted after full latency.
      for (int k = 0; k < 9; k++) step(1'b0, 2'b10);
      check("hold_level_before_rst", int'(btn_level), 1);
      step(1'b1, 2'b10);
      step(1'b1, 2'b10);
      check("rst_outputs_zero", int'({btn_level, btn_press, btn_release, any_press}), 0);
      first = -1;
      cnt = 0;
      for (int k = 1; k <= 26; k++) begin
         step(1'b0, 2'b10);
         if (btn_press[0]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      check("rst_reaccept_step", first, 6);
`ifdef BTN_AUTOREPEAT_EN
      check("rst_press_count", cnt, 5);
`else
      check("rst_press_count", cnt, 1);
`endif
      for (int k = 0; k < 8; k++) step(1'b0, 2'b11);

      // Random: slow-changing pins with bursts of bouncing and occasional reset pulses.
      for (int k = 0; k < 4000; k++) begin
         logic [N-1:0] b;
         logic r;
         b = btn;
         if ((k / 300) % 3 == 1) begin
            if ($urandom_range(0, 2) == 0) b[$urandom_range(0, N-1)] ^= 1'b1;
         end else if ($urandom_range(0, 11) == 0) begin
            b[$urandom_range(0, N-1)] ^= 1'b1;
         end
         r = ($urandom_range(0, 399) == 0);
         step(r, b);
      end
      step(1'b0, btn);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
